axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares the single AXI read channel (AR + R) of a core between NUM_REQ burst-read requesters: instruction cache, data cache and, later, a prefetcher.
- Grants one requester at a time, round-robin. Forwards its AR beat downstream, then routes R beats back to it until the last beat.
- Sits between the per-core caches and the AXI interconnect master port.

Parameters:
- NUM_REQ, 2, number of requesters (index 0 = instruction cache); range 2..8.
- ADDR_SIZE, 32, AXI address width.
- DATA_SIZE, 32, AXI read data width.
- LEN_W, 8, AXI arlen width.

Ports:
- i_aclk  input  1  system clock.
- i_areset  input  1  asynchronous active-high reset.
- i_ar_valid  input  NUM_REQ  per-requester read-address valid.
- i_ar_addr  input  NUM_REQ*ADDR_SIZE  per-requester address; requester k occupies bits [k*ADDR_SIZE +: ADDR_SIZE].
- i_ar_len  input  NUM_REQ*LEN_W  per-requester burst length minus 1, same packing.
- o_ar_ready  output  NUM_REQ  per-requester address accepted.
- o_r_valid  output  NUM_REQ  per-requester read-data valid.
- o_r_data  output  DATA_SIZE  read data, shared by all requesters.
- o_r_resp  output  2  read response, shared.
- o_r_last  output  1  last beat, shared.
- i_r_ready  input  NUM_REQ  per-requester read-data ready.
- o_m_ar_valid  output  1  downstream AR valid.
- o_m_ar_addr  output  ADDR_SIZE  downstream AR address.
- o_m_ar_len  output  LEN_W  downstream AR length.
- i_m_ar_ready  input  1  downstream AR ready.
- i_m_r_valid  input  1  downstream R valid.
- i_m_r_data  input  DATA_SIZE  downstream R data.
- i_m_r_resp  input  2  downstream R response.
- i_m_r_last  input  1  downstream R last.
- o_m_r_ready  output  1  downstream R ready.
- o_grant  output  $clog2(NUM_REQ)  index of current owner; valid while o_busy = 1.
- o_busy  output  1  channel owned (state ADDR or DATA).
- o_len_err  output  1  sticky: beat count did not match arlen at rlast.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high. i_areset forces:
  - state IDLE, all outputs 0;
  - last_grant = NUM_REQ-1, so requester 0 has first priority;
  - beat counter 0.
- Reset asserted mid-burst abandons the burst. No handshake is completed after reset.
- State IDLE:
  - If any i_ar_valid is set, select the first set bit searching upward from last_grant+1 (modulo NUM_REQ).
  - Register that index into grant; register its addr and len into o_m_ar_addr and o_m_ar_len; go to ADDR.
  - Latency: i_ar_valid sampled at edge N gives o_m_ar_valid = 1 after edge N.
- State ADDR:
  - o_m_ar_valid = 1; addr and len stay stable.
  - o_ar_ready[grant] = i_m_ar_ready (combinational); all other o_ar_ready bits are 0.
  - On i_m_ar_ready: clear the beat counter, go to DATA.
  - A requester dropping i_ar_valid while in ADDR is a protocol violation. The arbiter still completes the registered request.
- State DATA:
  - o_r_valid[grant] = i_m_r_valid; other o_r_valid bits 0.
  - o_m_r_ready = i_r_ready[grant]; other requesters' i_r_ready are ignored.
  - o_r_data, o_r_resp and o_r_last are combinational pass-throughs.
  - Each beat handshake (i_m_r_valid and o_m_r_ready both 1) increments the LEN_W-bit beat counter.
  - On a handshake with i_m_r_last = 1:
    - if counter != o_m_ar_len, set o_len_err; it stays set until reset;
    - last_grant = grant; go to IDLE.
- o_m_ar_valid is 0 outside ADDR. o_m_r_ready is 0 outside DATA.
- Only one transaction is outstanding at a time; no AR is issued until the previous rlast handshake.
- R beats arriving outside DATA are not accepted (o_m_r_ready = 0).
- A new request arriving on the same edge as rlast is seen in IDLE on the next edge. Minimum gap between bursts is one idle cycle.
- Round-robin fairness: with all requesters continuously requesting, grants cycle 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 bursts.
- o_busy = (state != IDLE). o_grant holds its value in IDLE.

Test Plan:
- Single requester: NUM_REQ=2, req 0 asserts addr 0x0000_1000, len 7. Expect:
  - o_m_ar_valid one cycle later with addr 0x1000, len 7;
  - o_ar_ready[0] pulses together with i_m_ar_ready;
  - 8 beats (data 0xA0..0xA7) reach req 0 only, o_r_valid[1] stays 0;
  - o_busy drops after the rlast beat; o_len_err = 0.
- Simultaneous requests: req 0 addr 0x100 and req 1 addr 0x200, both asserted the cycle after reset. Expect:
  - grant 0 first, then grant 1;
  - with both still requesting after that, the next grant is 0.
- Backpressure: during a burst to req 1, toggle i_r_ready[1] 1,0,0,1 and hold i_m_r_valid. Expect:
  - o_m_r_ready follows i_r_ready[1];
  - beat counter advances only on handshake cycles;
  - toggling i_r_ready[0] has no effect.
- Length mismatch: len 3, downstream asserts rlast on beat 2 (counter = 1). Expect o_len_err = 1, state IDLE, and o_len_err still set after the next correct burst.
- Reset mid-burst: assert i_areset after 2 of 8 beats. Expect:
  - all outputs 0 immediately (asynchronous);
  - after deassertion, the first pending request goes to req 0.
- AR stall: hold i_m_ar_ready = 0 for 5 cycles. Expect o_m_ar_valid, addr and len stable all 5 cycles and no o_ar_ready pulse.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel (AR + R)
// between NUM_REQ burst-read requesters; one burst outstanding at a time.
module axi_read_arbiter #(
    parameter  int NUM_REQ   = 2,
    parameter  int ADDR_SIZE = 32,
    parameter  int DATA_SIZE = 32,
    parameter  int LEN_W     = 8,
    localparam int GW        = $clog2(NUM_REQ)
) (
    input  logic                         i_aclk,
    input  logic                         i_areset,
    input  logic [NUM_REQ-1:0]           i_ar_valid,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] i_ar_addr,
    input  logic [NUM_REQ*LEN_W-1:0]     i_ar_len,
    output logic [NUM_REQ-1:0]           o_ar_ready,
    output logic [NUM_REQ-1:0]           o_r_valid,
    output logic [DATA_SIZE-1:0]         o_r_data,
    output logic [1:0]                   o_r_resp,
    output logic                         o_r_last,
    input  logic [NUM_REQ-1:0]           i_r_ready,
    output logic                         o_m_ar_valid,
    output logic [ADDR_SIZE-1:0]         o_m_ar_addr,
    output logic [LEN_W-1:0]             o_m_ar_len,
    input  logic                         i_m_ar_ready,
    input  logic                         i_m_r_valid,
    input  logic [DATA_SIZE-1:0]         i_m_r_data,
    input  logic [1:0]                   i_m_r_resp,
    input  logic                         i_m_r_last,
    output logic                         o_m_r_ready,
    output logic [GW-1:0]                o_grant,
    output logic                         o_busy,
    output logic                         o_len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t               state_q;
    logic [GW-1:0]        grant_q;
    logic [GW-1:0]        last_q;
    logic [GW-1:0]        sel_d;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     cnt_q;
    logic                 err_q;
    logic                 arv_q;
    logic                 busy_q;
    logic                 in_addr;
    logic                 in_data;
    logic                 beat_hs;

    // Walk downward so the last assignment wins: the first set bit after last_q.
    always_comb begin
        int j;
        sel_d = '0;
        j     = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = int'(last_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (i_ar_valid[j]) sel_d = GW'(j);
        end
    end

    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);
    assign beat_hs = in_data && i_m_r_valid && i_r_ready[grant_q];

    assign o_ar_ready  = (in_addr && i_m_ar_ready) ? (NUM_REQ'(1) << grant_q) : '0;
    assign o_r_valid   = (in_data && i_m_r_valid) ? (NUM_REQ'(1) << grant_q) : '0;
    assign o_m_r_ready = in_data && i_r_ready[grant_q];
    assign o_r_data    = in_data ? i_m_r_data : '0;
    assign o_r_resp    = in_data ? i_m_r_resp : '0;
    assign o_r_last    = in_data && i_m_r_last;

    assign o_m_ar_valid = arv_q;
    assign o_m_ar_addr  = addr_q;
    assign o_m_ar_len   = len_q;
    assign o_grant      = grant_q;
    assign o_busy       = busy_q;
    assign o_len_err    = err_q;

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            arv_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|i_ar_valid) begin
                        grant_q <= sel_d;
                        addr_q  <= i_ar_addr[sel_d*ADDR_SIZE +: ADDR_SIZE];
                        len_q   <= i_ar_len[sel_d*LEN_W +: LEN_W];
                        arv_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (i_m_ar_ready) begin
                        cnt_q   <= '0;
                        arv_q   <= 1'b0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (beat_hs) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        // Counter holds beats already taken, so the last beat sees arlen.
                        if (i_m_r_last) begin
                            if (cnt_q != len_q) err_q <= 1'b1;
                            last_q  <= grant_q;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench for axi_read_arbiter against a round-robin
// reference model of grants, beat routing and sticky length errors.
module tb_axi_read_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int GW = $clog2(N);

    logic            clk;
    logic            rst;
    logic [N-1:0]    arv;
    logic [N*AW-1:0] araddr;
    logic [N*LW-1:0] arlen;
    logic [N-1:0]    o_ar_ready;
    logic [N-1:0]    o_r_valid;
    logic [DW-1:0]   o_r_data;
    logic [1:0]      o_r_resp;
    logic            o_r_last;
    logic [N-1:0]    rrdy;
    logic            o_m_ar_valid;
    logic [AW-1:0]   o_m_ar_addr;
    logic [LW-1:0]   o_m_ar_len;
    logic            marready;
    logic            mrv;
    logic [DW-1:0]   mrd;
    logic [1:0]      mresp;
    logic            mlast;
    logic            o_m_r_ready;
    logic [GW-1:0]   o_grant;
    logic            o_busy;
    logic            o_len_err;

    axi_read_arbiter #(
        .NUM_REQ(N), .ADDR_SIZE(AW), .DATA_SIZE(DW), .LEN_W(LW)
    ) dut (
        .i_aclk       (clk),
        .i_areset     (rst),
        .i_ar_valid   (arv),
        .i_ar_addr    (araddr),
        .i_ar_len     (arlen),
        .o_ar_ready   (o_ar_ready),
        .o_r_valid    (o_r_valid),
        .o_r_data     (o_r_data),
        .o_r_resp     (o_r_resp),
        .o_r_last     (o_r_last),
        .i_r_ready    (rrdy),
        .o_m_ar_valid (o_m_ar_valid),
        .o_m_ar_addr  (o_m_ar_addr),
        .o_m_ar_len   (o_m_ar_len),
        .i_m_ar_ready (marready),
        .i_m_r_valid  (mrv),
        .i_m_r_data   (mrd),
        .i_m_r_resp   (mresp),
        .i_m_r_last   (mlast),
        .o_m_r_ready  (o_m_r_ready),
        .o_grant      (o_grant),
        .o_busy       (o_busy),
        .o_len_err    (o_len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs;
    int errs;
    int m_last;
    bit m_err;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++)
            if (mask[(m_last + k) % N]) return (m_last + k) % N;
        return -1;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_arv"}, o_m_ar_valid, 0);
        check({tag, "_rrdy"}, o_m_r_ready, 0);
        check({tag, "_rvld"}, o_r_valid, 0);
        check({tag, "_ardy"}, o_ar_ready, 0);
        check({tag, "_gnt"}, o_grant, 0);
        check({tag, "_lerr"}, o_len_err, 0);
        check({tag, "_addr"}, o_m_ar_addr, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_zero("rst");
        m_last = N - 1;
        m_err  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; the pending mask is sampled next edge.
    task automatic run_burst(input int delta, input int stall, input bit bp,
                             input bit keep, input logic [31:0] dbase,
                             input int abort_at);
        int g;
        int nb;
        int b;
        int cyc;
        logic [AW-1:0] ea;
        logic [LW-1:0] el;
        g = rr_pick(arv);
        if (g < 0) begin
            check("nopend", 0, 1);
            return;
        end
        ea = araddr[g*AW +: AW];
        el = arlen[g*LW +: LW];
        nb = int'(el) + 1 + delta;
        @(posedge clk);
        @(negedge clk);
        check("arvalid", o_m_ar_valid, 1);
        check("grant", o_grant, g);
        check("busy", o_busy, 1);
        check("araddr", o_m_ar_addr, ea);
        check("arlen", o_m_ar_len, el);
        for (int s = 0; s < stall; s++) begin
            check("stall_ardy", o_ar_ready, 0);
            @(negedge clk);
            check("stall_arv", o_m_ar_valid, 1);
            check("stall_addr", o_m_ar_addr, ea);
            check("stall_len", o_m_ar_len, el);
        end
        marready = 1'b1;
        #1;
        check("ardy", o_ar_ready, 1 << g);
        @(posedge clk);
        #1;
        marready = 1'b0;
        if (!keep) arv[g] = 1'b0;
        @(negedge clk);
        check("arv_off", o_m_ar_valid, 0);
        b   = 0;
        cyc = 0;
        while (b < nb && cyc < 300) begin
            if (abort_at >= 0 && b == abort_at) begin
                rst = 1'b1;
                mrv = 1'b0;
                #1;
                check_idle_zero("abort");
                m_last = N - 1;
                m_err  = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            mrv   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            mrd   = dbase + b;
            mresp = 2'($urandom);
            mlast = (b == nb - 1);
            rrdy  = bp ? N'($urandom) : '1;
            #1;
            check("rvalid", o_r_valid, mrv ? (1 << g) : 0);
            check("mrready", o_m_r_ready, rrdy[g]);
            if (mrv) begin
                check("rdata", o_r_data, mrd);
                check("rresp", o_r_resp, mresp);
                check("rlast", o_r_last, mlast);
            end
            if (mrv && rrdy[g]) b++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 300) check("beat_timeout", 0, 1);
        mrv   = 1'b0;
        mlast = 1'b0;
        m_err  = m_err | (nb != int'(el) + 1);
        m_last = g;
        #1;
        check("done_busy", o_busy, 0);
        check("done_mrrdy", o_m_r_ready, 0);
        check("len_err", o_len_err, m_err);
    endtask

    initial begin
        vecs     = 0;
        errs     = 0;
        rst      = 1'b1;
        arv      = '0;
        araddr   = '0;
        arlen    = '0;
        rrdy     = '0;
        marready = 1'b0;
        mrv      = 1'b0;
        mrd      = '0;
        mresp    = '0;
        mlast    = 1'b0;
        m_last   = N - 1;
        m_err    = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("init");
        rst = 1'b0;

        // single requester, 8 beats A0..A7
        @(negedge clk);
        araddr[0 +: AW] = 32'h0000_1000;
        arlen[0 +: LW]  = 8'd7;
        arv             = 2'b01;
        run_burst(0, 0, 0, 0, 32'hA0, -1);

        // simultaneous requests right after reset: 0, 1, 0
        do_reset();
        araddr[0 +: AW]  = 32'h100;
        araddr[AW +: AW] = 32'h200;
        arlen[0 +: LW]   = 8'd3;
        arlen[LW +: LW]  = 8'd3;
        arv              = 2'b11;
        run_burst(0, 0, 0, 1, 32'h10, -1);
        check("rr_first", m_last, 0);
        run_burst(0, 0, 0, 1, 32'h20, -1);
        check("rr_second", m_last, 1);
        run_burst(0, 0, 0, 0, 32'h30, -1);
        check("rr_third", m_last, 0);

        // backpressure on requester 1
        arv            = 2'b10;
        arlen[LW +: LW] = 8'd5;
        run_burst(0, 1, 1, 0, 32'h40, -1);

        // short burst flags length error; stays set after a good burst
        arv            = 2'b01;
        arlen[0 +: LW] = 8'd3;
        run_burst(-2, 0, 0, 0, 32'h50, -1);
        arv = 2'b01;
        run_burst(0, 0, 0, 0, 32'h60, -1);

        // AR stall of 5 cycles
        arv            = 2'b10;
        arlen[LW +: LW] = 8'd2;
        run_burst(0, 5, 0, 0, 32'h70, -1);

        // reset after 2 of 8 beats, then requester 0 wins
        arv            = 2'b10;
        arlen[LW +: LW] = 8'd7;
        run_burst(0, 0, 0, 1, 32'h80, 2);
        arv = 2'b11;
        run_burst(0, 0, 0, 0, 32'h90, -1);
        check("rst_winner", m_last, 0);

        for (int it = 0; it < 30; it++) begin
            int dl;
            arv = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++) begin
                araddr[k*AW +: AW] = $urandom;
                arlen[k*LW +: LW]  = LW'($urandom_range(0, 5));
            end
            dl = ($urandom_range(0, 7) == 0) ? 1 : 0;
            run_burst(dl, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
